// File: rtl/memory_access.sv
// MIPS MEM stage: byte-lane data RAM with aligned B/H/W loads and stores, branch resolve, MEM/WB registers.
// Optional `MEM_DEBUG_PORT_EN adds a second, read-first debug read port (debug_addr/debug_data).
module memory_access #(
  parameter int len         = 32,
  parameter int NB          = $clog2(len),
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2,
  parameter int ram_depth   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [len-1:0]         in_pc_branch,
  input  logic [len-1:0]         in_alu,
  input  logic                   in_zero_flag,
  input  logic [len-1:0]         in_reg2,
  input  logic [NB-1:0]          in_write_reg,
  input  logic [len_mem_bus-1:0] memory_bus,
  input  logic [len_wb_bus-1:0]  writeBack_bus,
`ifdef MEM_DEBUG_PORT_EN
  input  logic [len-1:0]         debug_addr,
  output logic [len-1:0]         debug_data,
`endif
  output logic                   out_pc_src,
  output logic [len-1:0]         out_pc_branch,
  output logic [len-1:0]         out_mem_data,
  output logic [len-1:0]         out_alu,
  output logic [NB-1:0]          out_write_reg,
  output logic [len_wb_bus-1:0]  writeBack_bus_out,
  output logic                   out_misaligned
);
  localparam int AW = $clog2(ram_depth);

  logic          w_beq, w_bne, w_mem_read, w_mem_write, w_load_unsigned;
  logic [1:0]    w_size;
  logic          w_is_byte, w_is_half, w_misaligned_addr, w_store;
  logic [AW-1:0] w_word_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rd_word;

  assign w_beq           = memory_bus[8];
  assign w_bne           = memory_bus[7];
  assign w_mem_read      = memory_bus[6];
  assign w_mem_write     = memory_bus[5];
  assign w_size          = memory_bus[4:3];
  assign w_load_unsigned = memory_bus[2];

  assign out_pc_src    = (w_beq & in_zero_flag) | (w_bne & ~in_zero_flag);
  assign out_pc_branch = in_pc_branch;

  // Reserved size 2'b10 falls through to word behaviour.
  assign w_is_byte         = (w_size == 2'b00);
  assign w_is_half         = (w_size == 2'b01);
  assign w_misaligned_addr = w_is_byte ? 1'b0 : (w_is_half ? in_alu[0] : (in_alu[1:0] != 2'b00));
  assign w_word_idx        = in_alu[AW+1:2];
  assign w_store           = w_mem_write & ~w_misaligned_addr & ~reset;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = in_reg2[31:0];
    if (w_is_byte) begin
      w_be    = 4'b0001 << in_alu[1:0];
      w_wdata = {4{in_reg2[7:0]}};
    end else if (w_is_half) begin
      w_be    = in_alu[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{in_reg2[15:0]}};
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  logic [AW-1:0] w_dbg_idx;
  assign w_dbg_idx = debug_addr[AW+1:2];
`endif

  // One RAM per byte lane keeps byte-enable writes as plain per-lane write enables.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane_mem [ram_depth];
      logic [7:0] r_rd_byte;

      always_ff @(posedge clk) begin
        if (w_store && w_be[gi]) begin
          r_lane_mem[w_word_idx] <= w_wdata[8*gi +: 8];
        end
        r_rd_byte <= r_lane_mem[w_word_idx];
      end
      assign w_rd_word[8*gi +: 8] = r_rd_byte;

`ifdef MEM_DEBUG_PORT_EN
      logic [7:0] r_dbg_byte;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_dbg_byte <= 8'h00;
        end else begin
          r_dbg_byte <= r_lane_mem[w_dbg_idx];
        end
      end
      assign debug_data[8*gi +: 8] = r_dbg_byte;
`endif
    end
  endgenerate

  logic            r_load_ok, r_load_unsigned, r_misaligned;
  logic [1:0]      r_size, r_lane;
  logic [len-1:0]  r_alu;
  logic [NB-1:0]   r_write_reg;
  logic [len_wb_bus-1:0] r_wb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_ok       <= 1'b0;
      r_load_unsigned <= 1'b0;
      r_size          <= 2'b00;
      r_lane          <= 2'b00;
      r_alu           <= '0;
      r_write_reg     <= '0;
      r_wb            <= '0;
      r_misaligned    <= 1'b0;
    end else begin
      r_load_ok       <= w_mem_read & ~w_misaligned_addr;
      r_load_unsigned <= w_load_unsigned;
      r_size          <= w_size;
      r_lane          <= in_alu[1:0];
      r_alu           <= in_alu;
      r_write_reg     <= in_write_reg;
      r_wb            <= writeBack_bus;
      r_wb[1]         <= writeBack_bus[1] & ~(w_mem_read & w_misaligned_addr);
      if ((w_mem_read | w_mem_write) & w_misaligned_addr) begin
        r_misaligned <= 1'b1;
      end
    end
  end

  logic [7:0]     w_sel_byte;
  logic [15:0]    w_sel_half;
  logic [len-1:0] w_mem_data;

  assign w_sel_byte = w_rd_word[8*r_lane +: 8];
  assign w_sel_half = r_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_mem_data = '0;
    if (r_load_ok) begin
      case (r_size)
        2'b00:   w_mem_data = {{(len-8){~r_load_unsigned & w_sel_byte[7]}}, w_sel_byte};
        2'b01:   w_mem_data = {{(len-16){~r_load_unsigned & w_sel_half[15]}}, w_sel_half};
        default: w_mem_data = w_rd_word;
      endcase
    end
  end

  assign out_mem_data      = w_mem_data;
  assign out_alu           = r_alu;
  assign out_write_reg     = r_write_reg;
  assign writeBack_bus_out = r_wb;
  assign out_misaligned    = r_misaligned;

  logic w_unused;
`ifdef MEM_DEBUG_PORT_EN
  assign w_unused = ^{in_alu[len-1:AW+2], in_reg2[len-1:0], memory_bus[1:0],
                      debug_addr[len-1:AW+2], debug_addr[1:0]};
`else
  assign w_unused = ^{in_alu[len-1:AW+2], in_reg2[len-1:0], memory_bus[1:0]};
`endif
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: word/byte/half accesses, alignment errors, branches,
// aliasing, read-first collisions, mid-stream reset and (if enabled) the debug read port.
module tb_memory_access;
  localparam logic [8:0] BUS_NOP = 9'h000;
  localparam logic [8:0] BUS_SW  = 9'h038;
  localparam logic [8:0] BUS_LW  = 9'h058;
  localparam logic [8:0] BUS_SB  = 9'h020;
  localparam logic [8:0] BUS_LB  = 9'h040;
  localparam logic [8:0] BUS_LBU = 9'h044;
  localparam logic [8:0] BUS_SH  = 9'h028;
  localparam logic [8:0] BUS_LH  = 9'h048;
  localparam logic [8:0] BUS_LHU = 9'h04C;
  localparam logic [8:0] BUS_RW  = 9'h078;
  localparam logic [8:0] BUS_BEQ = 9'h100;
  localparam logic [8:0] BUS_BNE = 9'h080;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_pc_branch, in_alu, in_reg2;
  logic        in_zero_flag;
  logic [4:0]  in_write_reg;
  logic [8:0]  memory_bus;
  logic [1:0]  writeBack_bus;
  logic        out_pc_src;
  logic [31:0] out_pc_branch, out_mem_data, out_alu;
  logic [4:0]  out_write_reg;
  logic [1:0]  writeBack_bus_out;
  logic        out_misaligned;
`ifdef MEM_DEBUG_PORT_EN
  logic [31:0] debug_addr, debug_data;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .reset(reset),
    .in_pc_branch(in_pc_branch), .in_alu(in_alu), .in_zero_flag(in_zero_flag),
    .in_reg2(in_reg2), .in_write_reg(in_write_reg),
    .memory_bus(memory_bus), .writeBack_bus(writeBack_bus),
`ifdef MEM_DEBUG_PORT_EN
    .debug_addr(debug_addr), .debug_data(debug_data),
`endif
    .out_pc_src(out_pc_src), .out_pc_branch(out_pc_branch), .out_mem_data(out_mem_data),
    .out_alu(out_alu), .out_write_reg(out_write_reg),
    .writeBack_bus_out(writeBack_bus_out), .out_misaligned(out_misaligned)
  );

  // Drive one instruction, clock it in, then settle 1 ns past the edge for sampling.
  task automatic issue(input logic [8:0] bus, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] reg2, input logic [4:0] wreg);
    memory_bus    = bus;
    writeBack_bus = wb;
    in_alu        = alu;
    in_reg2       = reg2;
    in_write_reg  = wreg;
    $display("[TB] txn reset=%0b bus=%03h wb=%0b alu=%08h reg2=%08h rd=%0d",
             reset, bus, wb, alu, reg2, wreg);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issue(BUS_LW, 2'b11, 32'h0000_0010, 32'h0, 5'd9);
    issue(BUS_LW, 2'b11, 32'h0000_0011, 32'h0, 5'd9);
    tests++; if (out_mem_data !== 32'h0) begin failed++; $display("FAIL reset_mem_data: got %h want %h", out_mem_data, 32'h0); end
    tests++; if (out_alu !== 32'h0) begin failed++; $display("FAIL reset_alu: got %h want %h", out_alu, 32'h0); end
    tests++; if (out_write_reg !== 5'd0) begin failed++; $display("FAIL reset_write_reg: got %0d want 0", out_write_reg); end
    tests++; if (writeBack_bus_out !== 2'b00) begin failed++; $display("FAIL reset_wb: got %b want 00", writeBack_bus_out); end
    tests++; if (out_misaligned !== 1'b0) begin failed++; $display("FAIL reset_misaligned: got %b want 0", out_misaligned); end
`ifdef MEM_DEBUG_PORT_EN
    tests++; if (debug_data !== 32'h0) begin failed++; $display("FAIL reset_debug_data: got %h want 0", debug_data); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_word();
    issue(BUS_SW, 2'b00, 32'h10, 32'hDEADBEEF, 5'd5);
    tests++; if (out_alu !== 32'h10) begin failed++; $display("FAIL sw_alu: got %h want %h", out_alu, 32'h10); end
    tests++; if (out_mem_data !== 32'h0) begin failed++; $display("FAIL sw_no_read_data: got %h want 0", out_mem_data); end
    issue(BUS_LW, 2'b11, 32'h10, 32'h0, 5'd7);
    tests++; if (out_mem_data !== 32'hDEADBEEF) begin failed++; $display("FAIL lw_word: got %h want %h", out_mem_data, 32'hDEADBEEF); end
    tests++; if (out_alu !== 32'h10) begin failed++; $display("FAIL lw_alu: got %h want %h", out_alu, 32'h10); end
    tests++; if (out_write_reg !== 5'd7) begin failed++; $display("FAIL lw_write_reg: got %0d want 7", out_write_reg); end
    tests++; if (writeBack_bus_out !== 2'b11) begin failed++; $display("FAIL lw_wb: got %b want 11", writeBack_bus_out); end
  endtask

  task automatic test_byte();
    issue(BUS_SW, 2'b00, 32'h10, 32'h0, 5'd0);
    issue(BUS_SB, 2'b00, 32'h13, 32'h1234_5680, 5'd0);
    issue(BUS_LB, 2'b11, 32'h13, 32'h0, 5'd1);
    tests++; if (out_mem_data !== 32'hFFFFFF80) begin failed++; $display("FAIL lb_sign: got %h want %h", out_mem_data, 32'hFFFFFF80); end
    issue(BUS_LBU, 2'b11, 32'h13, 32'h0, 5'd1);
    tests++; if (out_mem_data !== 32'h00000080) begin failed++; $display("FAIL lbu_zero: got %h want %h", out_mem_data, 32'h80); end
    issue(BUS_LB, 2'b11, 32'h12, 32'h0, 5'd1);
    tests++; if (out_mem_data !== 32'h0) begin failed++; $display("FAIL lb_other_lane: got %h want 0", out_mem_data); end
    issue(BUS_LW, 2'b11, 32'h10, 32'h0, 5'd1);
    tests++; if (out_mem_data !== 32'h80000000) begin failed++; $display("FAIL lw_after_sb: got %h want %h", out_mem_data, 32'h80000000); end
  endtask

  task automatic test_half();
    issue(BUS_SW, 2'b00, 32'h20, 32'h1122_3344, 5'd0);
    issue(BUS_SH, 2'b00, 32'h22, 32'hABCD_1234, 5'd0);
    issue(BUS_LH, 2'b11, 32'h22, 32'h0, 5'd2);
    tests++; if (out_mem_data !== 32'h00001234) begin failed++; $display("FAIL lh_hi: got %h want %h", out_mem_data, 32'h1234); end
    tests++; if (out_misaligned !== 1'b0) begin failed++; $display("FAIL aligned_no_flag: got %b want 0", out_misaligned); end
    issue(BUS_LH, 2'b11, 32'h21, 32'h0, 5'd2);
    tests++; if (out_misaligned !== 1'b1) begin failed++; $display("FAIL lh_misaligned_flag: got %b want 1", out_misaligned); end
    tests++; if (writeBack_bus_out !== 2'b01) begin failed++; $display("FAIL lh_misaligned_wb: got %b want 01", writeBack_bus_out); end
    tests++; if (out_mem_data !== 32'h0) begin failed++; $display("FAIL lh_misaligned_data: got %h want 0", out_mem_data); end
    issue(BUS_SH, 2'b00, 32'h23, 32'hFFFF_FFFF, 5'd0);
    issue(BUS_LW, 2'b11, 32'h20, 32'h0, 5'd2);
    tests++; if (out_mem_data !== 32'h12343344) begin failed++; $display("FAIL misaligned_store_dropped: got %h want %h", out_mem_data, 32'h12343344); end
    tests++; if (out_misaligned !== 1'b1) begin failed++; $display("FAIL misaligned_sticky: got %b want 1", out_misaligned); end
    issue(BUS_SH, 2'b00, 32'h20, 32'h0000_8001, 5'd0);
    issue(BUS_LH, 2'b11, 32'h20, 32'h0, 5'd3);
    tests++; if (out_mem_data !== 32'hFFFF8001) begin failed++; $display("FAIL lh_sign: got %h want %h", out_mem_data, 32'hFFFF8001); end
    issue(BUS_LHU, 2'b11, 32'h20, 32'h0, 5'd3);
    tests++; if (out_mem_data !== 32'h00008001) begin failed++; $display("FAIL lhu_zero: got %h want %h", out_mem_data, 32'h8001); end
  endtask

  task automatic test_branch();
    in_pc_branch = 32'h0000_4444;
    memory_bus = BUS_BEQ; in_zero_flag = 1'b1; #1;
    tests++; if (out_pc_src !== 1'b1) begin failed++; $display("FAIL beq_taken: got %b want 1", out_pc_src); end
    tests++; if (out_pc_branch !== 32'h4444) begin failed++; $display("FAIL pc_branch_pass: got %h want %h", out_pc_branch, 32'h4444); end
    memory_bus = BUS_BEQ; in_zero_flag = 1'b0; #1;
    tests++; if (out_pc_src !== 1'b0) begin failed++; $display("FAIL beq_not_taken: got %b want 0", out_pc_src); end
    memory_bus = BUS_BNE; in_zero_flag = 1'b1; #1;
    tests++; if (out_pc_src !== 1'b0) begin failed++; $display("FAIL bne_not_taken: got %b want 0", out_pc_src); end
    memory_bus = BUS_BNE; in_zero_flag = 1'b0; #1;
    tests++; if (out_pc_src !== 1'b1) begin failed++; $display("FAIL bne_taken: got %b want 1", out_pc_src); end
    memory_bus = BUS_BEQ | BUS_BNE; in_zero_flag = 1'b0; #1;
    tests++; if (out_pc_src !== 1'b1) begin failed++; $display("FAIL both_taken: got %b want 1", out_pc_src); end
    in_zero_flag = 1'b1;
    issue(BUS_NOP, 2'b00, 32'h10, 32'hFFFF_FFFF, 5'd0);
    tests++; if (out_pc_src !== 1'b0) begin failed++; $display("FAIL bubble_pc_src: got %b want 0", out_pc_src); end
    tests++; if (out_mem_data !== 32'h0) begin failed++; $display("FAIL bubble_data: got %h want 0", out_mem_data); end
    in_zero_flag = 1'b0;
    issue(BUS_LW, 2'b11, 32'h10, 32'h0, 5'd4);
    tests++; if (out_mem_data !== 32'h80000000) begin failed++; $display("FAIL bubble_no_write: got %h want %h", out_mem_data, 32'h80000000); end
  endtask

  task automatic test_alias();
    issue(BUS_SW, 2'b00, 32'h10 + 32'd4096, 32'hCAFE_F00D, 5'd0);
    issue(BUS_LW, 2'b11, 32'h10, 32'h0, 5'd6);
    tests++; if (out_mem_data !== 32'hCAFEF00D) begin failed++; $display("FAIL alias_wrap: got %h want %h", out_mem_data, 32'hCAFEF00D); end
  endtask

  task automatic test_back_to_back();
    issue(BUS_SW, 2'b00, 32'h30, 32'hAAAA_5555, 5'd0);
    issue(BUS_RW, 2'b11, 32'h30, 32'h0102_0304, 5'd8);
    tests++; if (out_mem_data !== 32'hAAAA5555) begin failed++; $display("FAIL read_first_old: got %h want %h", out_mem_data, 32'hAAAA5555); end
    issue(BUS_LW, 2'b11, 32'h30, 32'h0, 5'd8);
    tests++; if (out_mem_data !== 32'h01020304) begin failed++; $display("FAIL read_first_new: got %h want %h", out_mem_data, 32'h01020304); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    issue(BUS_SW, 2'b11, 32'h30, 32'h0000_0099, 5'd9);
    tests++; if (out_misaligned !== 1'b0) begin failed++; $display("FAIL midreset_misaligned: got %b want 0", out_misaligned); end
    tests++; if (out_alu !== 32'h0) begin failed++; $display("FAIL midreset_alu: got %h want 0", out_alu); end
    tests++; if (writeBack_bus_out !== 2'b00) begin failed++; $display("FAIL midreset_wb: got %b want 00", writeBack_bus_out); end
    reset = 1'b0;
    issue(BUS_LW, 2'b11, 32'h30, 32'h0, 5'd8);
    tests++; if (out_mem_data !== 32'h01020304) begin failed++; $display("FAIL midreset_store_dropped: got %h want %h", out_mem_data, 32'h01020304); end
  endtask

`ifdef MEM_DEBUG_PORT_EN
  task automatic test_debug();
    debug_addr = 32'h13;
    issue(BUS_NOP, 2'b00, 32'h0, 32'h0, 5'd0);
    tests++; if (debug_data !== 32'hCAFEF00D) begin failed++; $display("FAIL debug_idle: got %h want %h", debug_data, 32'hCAFEF00D); end
    issue(BUS_SW, 2'b00, 32'h10, 32'h0000_0055, 5'd0);
    tests++; if (debug_data !== 32'hCAFEF00D) begin failed++; $display("FAIL debug_read_first: got %h want %h", debug_data, 32'hCAFEF00D); end
    issue(BUS_NOP, 2'b00, 32'h0, 32'h0, 5'd0);
    tests++; if (debug_data !== 32'h00000055) begin failed++; $display("FAIL debug_new: got %h want %h", debug_data, 32'h55); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_pc_branch = 32'h0; in_alu = 32'h0; in_reg2 = 32'h0; in_zero_flag = 1'b0;
    in_write_reg = 5'd0; memory_bus = BUS_NOP; writeBack_bus = 2'b00;
`ifdef MEM_DEBUG_PORT_EN
    debug_addr = 32'h0;
`endif
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_branch();
    test_alias();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_DEBUG_PORT_EN
    test_debug();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
